// File: rtl/rx_descrambler_deframer.sv
// Receive side of the wake-up/sync link: strips the self-synchronising
// scrambler, packs payload bytes MSB-first and grades them against 0xF0.
module rx_descrambler_deframer #(
   parameter int PREAMBLE_LEN = 432,
   parameter int PAYLOAD_LEN  = 768,
   parameter int TAIL_LEN     = 16,
   parameter int ERR_W        = 16
) (
   input  logic             clki,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             bit_en,
   input  logic             bit_in,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   output logic             busy,
   output logic             frame_done,
   output logic             preamble_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int MAX_A  = (PREAMBLE_LEN > PAYLOAD_LEN) ? PREAMBLE_LEN : PAYLOAD_LEN;
   localparam int MAX_B  = (MAX_A > TAIL_LEN) ? MAX_A : TAIL_LEN;
   localparam int MAXLEN = (MAX_B > 8) ? MAX_B : 8;
   localparam int CNT_W  = $clog2(MAXLEN + 1);

   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_LEN - 1);
   localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      PAYLOAD,
      TAIL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       hist_q, hist_d;
   logic [6:0]       sr_q, sr_d;
   logic [7:0]       byte_q, byte_d;
   logic             bvalid_q, bvalid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             perr_q, perr_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic accept;
   logic descr;
   logic exp_bit;

   // The bit riding along with frame_start belongs to nobody.
   assign accept  = bit_en && !frame_start && (state_q != IDLE);
   assign descr   = bit_in ^ hist_q[0] ^ hist_q[3] ^ hist_q[4]
                  ^ hist_q[6] ^ hist_q[7];
   assign exp_bit = ~cnt_q[2];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hist_d   = hist_q;
      sr_d     = sr_q;
      byte_d   = byte_q;
      bvalid_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      perr_d   = perr_q;
      err_d    = err_q;

      if (frame_start) begin
         state_d = PREAMBLE;
         cnt_d   = '0;
         hist_d  = '0;
         sr_d    = '0;
         perr_d  = 1'b0;
         err_d   = '0;
         busy_d  = 1'b1;
      end else if (accept) begin
         hist_d = {hist_q[6:0], bit_in};
         cnt_d  = cnt_q + CNT_W'(1);
         unique case (state_q)
            PREAMBLE: begin
               if (bit_in) perr_d = 1'b1;
               if (cnt_q == PRE_LAST) begin
                  state_d = PAYLOAD;
                  cnt_d   = '0;
               end
            end
            PAYLOAD: begin
               sr_d = {sr_q[5:0], descr};
               if ((descr != exp_bit) && (err_q != '1))
                  err_d = err_q + ERR_W'(1);
               if (cnt_q[2:0] == 3'b111) begin
                  byte_d   = {sr_q, descr};
                  bvalid_d = 1'b1;
               end
               if (cnt_q == PAY_LAST) begin
                  state_d = TAIL;
                  cnt_d   = '0;
               end
            end
            TAIL: begin
               if (bit_in) perr_d = 1'b1;
               if (cnt_q == TAIL_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hist_q   <= '0;
         sr_q     <= '0;
         byte_q   <= '0;
         bvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         perr_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hist_q   <= hist_d;
         sr_q     <= sr_d;
         byte_q   <= byte_d;
         bvalid_q <= bvalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         perr_q   <= perr_d;
         err_q    <= err_d;
      end
   end

   assign byte_out     = byte_q;
   assign byte_valid   = bvalid_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign preamble_err = perr_q;
   assign err_cnt      = err_q;

endmodule

// File: tb/tb_rx_descrambler_deframer.sv
// Directed frames through the deframer; expected bytes are queued by the
// driver and consumed by a monitor on every byte_valid.
module tb_rx_descrambler_deframer;

   localparam int PRE   = 432;
   localparam int PAY   = 768;
   localparam int TL    = 16;
   localparam int FRAME = PRE + PAY + TL;

   logic clki = 1'b0;
   always #5 clki = ~clki;

   logic        rst, frame_start, bit_en, bit_in;
   logic [7:0]  byte_out, byte_out4;
   logic        byte_valid, busy, frame_done, preamble_err;
   logic        byte_valid4, busy4, frame_done4, preamble_err4;
   logic [15:0] err_cnt;
   logic [3:0]  err_cnt4;

   rx_descrambler_deframer dut (
      .clki(clki), .rst(rst), .frame_start(frame_start),
      .bit_en(bit_en), .bit_in(bit_in),
      .byte_out(byte_out), .byte_valid(byte_valid), .busy(busy),
      .frame_done(frame_done), .preamble_err(preamble_err),
      .err_cnt(err_cnt)
   );

   rx_descrambler_deframer #(.ERR_W(4)) dut4 (
      .clki(clki), .rst(rst), .frame_start(frame_start),
      .bit_en(bit_en), .bit_in(bit_in),
      .byte_out(byte_out4), .byte_valid(byte_valid4), .busy(busy4),
      .frame_done(frame_done4), .preamble_err(preamble_err4),
      .err_cnt(err_cnt4)
   );

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int mon_idx = 0;
   logic [7:0] mon_e;
   logic [7:0] exp_q[$];
   logic       frm [0:FRAME-1];
   logic [7:0] expb [0:PAY/8-1];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clki) begin
      if (byte_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL byte_unexpected got=%0h want=none", byte_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("byte%0d", mon_idx), {24'd0, byte_out}, {24'd0, mon_e});
         end
         mon_idx++;
      end
      if (frame_done === 1'b1) done_cnt++;
   end

   // Transmitter model: zero preamble/tail, 0xF0 payload through the scrambler.
   task automatic build_golden();
      logic [7:0] s;
      logic d, o;
      s = '0;
      for (int i = 0; i < FRAME; i++) frm[i] = 1'b0;
      for (int p = 0; p < PAY; p++) begin
         d = ((p % 8) < 4);
         o = d ^ s[0] ^ s[3] ^ s[4] ^ s[6] ^ s[7];
         s = {s[6:0], o};
         frm[PRE + p] = o;
      end
      for (int k = 0; k < PAY / 8; k++) expb[k] = 8'hF0;
   endtask

   task automatic start_frame(input logic en, input logic b);
      frame_start = 1'b1;
      bit_en      = en;
      bit_in      = b;
      @(negedge clki);
      frame_start = 1'b0;
      bit_en      = 1'b0;
      bit_in      = 1'b0;
      chk("busy_start", busy, 1);
      chk("err_clear", err_cnt, 0);
      chk("perr_clear", preamble_err, 0);
   endtask

   task automatic send_bits(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bit_en = 1'b1;
         bit_in = frm[i];
         if (i >= PRE && i < PRE + PAY && ((i - PRE) % 8) == 7)
            exp_q.push_back(expb[(i - PRE) / 8]);
         @(negedge clki);
         if (i == FRAME - 1) begin
            exp_done++;
            chk("frame_done", frame_done, 1);
            chk("busy_end", busy, 0);
         end
         if (gap > 0) begin
            bit_en = 1'b0;
            bit_in = 1'b0;
            repeat (gap) @(negedge clki);
         end
      end
      bit_en = 1'b0;
      bit_in = 1'b0;
      if (n == FRAME) begin
         if (gap == 0) @(negedge clki);
         chk("done_pulse", frame_done, 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      bit_en = 1'b0;
      bit_in = 1'b0;
      repeat (3) @(negedge clki);
      chk("rst_byte", byte_out, 0);
      chk("rst_bvalid", byte_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_perr", preamble_err, 0);
      chk("rst_err", err_cnt, 0);
      rst = 1'b0;
      @(negedge clki);

      build_golden();
      start_frame(1'b0, 1'b0);
      send_bits(FRAME, 2);
      chk("golden_err", err_cnt, 0);
      chk("golden_perr", preamble_err, 0);

      build_golden();
      frm[PRE + 100] = ~frm[PRE + 100];
      expb[12] = 8'hFC;
      expb[13] = 8'h28;
      start_frame(1'b0, 1'b0);
      send_bits(FRAME, 1);
      chk("flip_err", err_cnt, 6);
      chk("flip_err4", err_cnt4, 6);
      chk("flip_perr", preamble_err, 0);

      build_golden();
      frm[50] = 1'b1;
      start_frame(1'b0, 1'b0);
      send_bits(FRAME, 1);
      chk("pre50_err", err_cnt, 0);
      chk("pre50_perr", preamble_err, 1);
      repeat (10) @(negedge clki);
      chk("pre50_hold", preamble_err, 1);

      // Last preamble bit still sits in history for the first payload byte.
      build_golden();
      frm[PRE - 1] = 1'b1;
      expb[0] = 8'h6B;
      start_frame(1'b0, 1'b0);
      send_bits(FRAME, 1);
      chk("pre431_err", err_cnt, 5);
      chk("pre431_perr", preamble_err, 1);

      build_golden();
      start_frame(1'b0, 1'b0);
      send_bits(PRE + 300, 1);
      start_frame(1'b0, 1'b0);
      send_bits(FRAME, 1);
      chk("abort_err", err_cnt, 0);
      chk("abort_perr", preamble_err, 0);

      build_golden();
      start_frame(1'b0, 1'b0);
      send_bits(PRE + 100, 1);
      rst = 1'b1;
      @(negedge clki);
      rst = 1'b0;
      chk("mrst_byte", byte_out, 0);
      chk("mrst_bvalid", byte_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", frame_done, 0);
      chk("mrst_perr", preamble_err, 0);
      chk("mrst_err", err_cnt, 0);
      bit_en = 1'b1;
      bit_in = 1'b1;
      repeat (20) @(negedge clki);
      bit_en = 1'b0;
      bit_in = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_perr", preamble_err, 0);
      chk("idle_err", err_cnt, 0);

      build_golden();
      start_frame(1'b1, 1'b1);
      send_bits(FRAME, 0);
      chk("cont_err", err_cnt, 0);
      chk("cont_perr", preamble_err, 0);

      build_golden();
      for (int p = 0; p < PAY; p++) frm[PRE + p] = 1'b1;
      expb[0] = 8'h89;
      for (int k = 1; k < PAY / 8; k++) expb[k] = 8'h00;
      start_frame(1'b0, 1'b0);
      send_bits(FRAME, 0);
      chk("ones_err", err_cnt, 385);
      chk("ones_err4_sat", err_cnt4, 15);
      chk("ones_perr", preamble_err, 0);

      repeat (5) @(negedge clki);
      chk("queue_drained", exp_q.size(), 0);
      chk("done_count", done_cnt, exp_done);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
